// File: rtl/control_pipe.sv
`timescale 1ns/1ps
// control_pipe
//   Control-signal pipeline for a 5-stage in-order core. ID-stage decoded
//   control is carried through EX, MEM and WB. The block also generates the
//   load-use stall, the taken-branch redirect and the cache-miss freeze.
//
//   Optional feature: define CONTROL_PIPE_PERF_EN to add the saturating
//   stall/flush performance counters (stallCount, flushCount).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   regDst..branch, aluOp     ID-stage decoded control
//   idValid, idRs, idRt       ID instruction valid and source registers
//   memBusy                   cache miss: freeze every stage
//   aluZero                   EX-stage ALU zero flag
//   ex*/mem*/wb*              registered control per stage
//   exValid/memValid/wbValid  stage occupancy
//   stallId, flushIf          hold ID / kill IF-ID on redirect
//   branchTaken               EX branch resolved taken
//   stallCount, flushCount    perf counters (CONTROL_PIPE_PERF_EN only)
module control_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regDst,
  input  logic             aluSrc,
  input  logic             memToReg,
  input  logic             regWrite,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             branch,
  input  logic [2:0]       aluOp,
  input  logic             idValid,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             memBusy,
  input  logic             aluZero,
  output logic             exRegDst,
  output logic             exAluSrc,
  output logic             exMemRead,
  output logic             exMemWrite,
  output logic             exBranch,
  output logic             exMemToReg,
  output logic             exRegWrite,
  output logic [2:0]       exAluOp,
  output logic [4:0]       exRt,
  output logic             memMemRead,
  output logic             memMemWrite,
  output logic             memMemToReg,
  output logic             memRegWrite,
  output logic             wbMemToReg,
  output logic             wbRegWrite,
  output logic             exValid,
  output logic             memValid,
  output logic             wbValid,
  output logic             stallId,
  output logic             flushIf,
`ifdef CONTROL_PIPE_PERF_EN
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
`endif
  output logic             branchTaken
);

  logic rtMatch;
  logic exLoad;

  // Hazards are only meaningful while the pipe is moving, so memBusy masks
  // them all. A taken branch kills the ID instruction, so it wins over stall.
  always_comb begin
    rtMatch     = (exRt == idRs) | (exRt == idRt);
    branchTaken = exValid & exBranch & aluZero & ~memBusy;
    stallId     = exValid & exMemRead & idValid & rtMatch & ~memBusy & ~branchTaken;
    flushIf     = branchTaken;
  end

  // The ID instruction enters EX only if it is valid and neither killed nor
  // held; otherwise EX receives a bubble (all zero, including exRt).
  assign exLoad = idValid & ~stallId & ~branchTaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid     <= 1'b0;
      exRegDst    <= 1'b0;
      exAluSrc    <= 1'b0;
      exMemRead   <= 1'b0;
      exMemWrite  <= 1'b0;
      exBranch    <= 1'b0;
      exMemToReg  <= 1'b0;
      exRegWrite  <= 1'b0;
      exAluOp     <= 3'b000;
      exRt        <= 5'd0;
      memValid    <= 1'b0;
      memMemRead  <= 1'b0;
      memMemWrite <= 1'b0;
      memMemToReg <= 1'b0;
      memRegWrite <= 1'b0;
      wbValid     <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbRegWrite  <= 1'b0;
    end else if (!memBusy) begin
      exValid     <= exLoad;
      exRegDst    <= exLoad & regDst;
      exAluSrc    <= exLoad & aluSrc;
      exMemRead   <= exLoad & memRead;
      exMemWrite  <= exLoad & memWrite;
      exBranch    <= exLoad & branch;
      exMemToReg  <= exLoad & memToReg;
      exRegWrite  <= exLoad & regWrite;
      exAluOp     <= exLoad ? aluOp : 3'b000;
      exRt        <= exLoad ? idRt : 5'd0;
      memValid    <= exValid;
      memMemRead  <= exMemRead;
      memMemWrite <= exMemWrite;
      memMemToReg <= exMemToReg;
      memRegWrite <= exRegWrite;
      wbValid     <= memValid;
      wbMemToReg  <= memMemToReg;
      wbRegWrite  <= memRegWrite;
    end
  end

`ifdef CONTROL_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallId && (stallCount != CNT_MAX)) begin
        stallCount <= stallCount + CNT_ONE;
      end
      if (branchTaken && (flushCount != CNT_MAX)) begin
        flushCount <= flushCount + CNT_ONE;
      end
    end
  end
`else
  // Keeps the counter width parameter referenced when counters are absent.
  logic [CNT_W-1:0] unusedCntW;
  assign unusedCntW = '0;
`endif

endmodule
